// File: rtl/ddc_peak_capture.sv
// Pulse peak capture for the DDC channel-A input PIO.
// Tracks the maximum of each above-threshold pulse and holds the result until a
// rising edge on ack. Pulses that start while a result is pending are counted as missed.
module ddc_peak_capture #(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned MIN_LEN = 2,
  parameter int unsigned MISS_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] threshold,
  input  logic              ack,
  output logic [DATA_W-1:0] peak_out,
  output logic              peak_valid,
  output logic [LEN_W-1:0]  pulse_len,
  output logic [MISS_W-1:0] missed_count,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StPulse, StHold, StRearm} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d;
  logic [LEN_W-1:0]    run_len_q, run_len_d;
  logic [DATA_W-1:0]   peak_q, peak_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                valid_q, valid_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                ack_d_q;
  logic                prev_above_q, prev_above_d;

  logic above, below, ack_rise;

  // Next-state logic: sample classification, FSM transitions and result capture.
  always_comb begin
    above        = adc_valid && (adc_data >= threshold);
    below        = adc_valid && (adc_data < threshold);
    ack_rise     = ack && !ack_d_q;
    state_d      = state_q;
    run_max_d    = run_max_q;
    run_len_d    = run_len_q;
    peak_d       = peak_q;
    len_d        = len_q;
    valid_d      = valid_q;
    miss_d       = miss_q;
    // prev_above only follows valid samples; invalid cycles leave it alone.
    prev_above_d = adc_valid ? above : prev_above_q;

    unique case (state_q)
      StIdle: begin
        if (above) begin
          state_d      = StPulse;
          run_max_d    = adc_data;
          run_len_d    = LEN_W'(1);
          prev_above_d = 1'b0;
        end
      end
      StPulse: begin
        if (above) begin
          if (adc_data > run_max_q) run_max_d = adc_data;
          if (run_len_q != '1) run_len_d = run_len_q + LEN_W'(1);
        end else if (below) begin
          if (run_len_q >= LEN_W'(MIN_LEN)) begin
            peak_d  = run_max_q;
            len_d   = run_len_q;
            valid_d = 1'b1;
            state_d = StHold;
          end else begin
            state_d      = StIdle;
            prev_above_d = 1'b0;
          end
        end
      end
      StHold: begin
        if (above && !prev_above_q && (miss_q != '1)) miss_d = miss_q + MISS_W'(1);
        // A pulse still running at ack time must drain in REARM before re-arming.
        if (ack_rise) begin
          valid_d = 1'b0;
          if (prev_above_d) begin
            state_d = StRearm;
          end else begin
            state_d      = StIdle;
            prev_above_d = 1'b0;
          end
        end
      end
      StRearm: begin
        if (below) begin
          state_d      = StIdle;
          prev_above_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      run_max_q    <= '0;
      run_len_q    <= '0;
      peak_q       <= '0;
      len_q        <= '0;
      valid_q      <= 1'b0;
      miss_q       <= '0;
      ack_d_q      <= 1'b0;
      prev_above_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_max_q    <= run_max_d;
      run_len_q    <= run_len_d;
      peak_q       <= peak_d;
      len_q        <= len_d;
      valid_q      <= valid_d;
      miss_q       <= miss_d;
      ack_d_q      <= ack;
      prev_above_q <= prev_above_d;
    end
  end

  // Output mapping.
  always_comb begin
    peak_out     = peak_q;
    pulse_len    = len_q;
    peak_valid   = valid_q;
    missed_count = miss_q;
    busy         = (state_q != StIdle);
  end

endmodule

// File: doc/ddc_peak_capture.md
Name: ddc_peak_capture

Overview:
- Upstream stage of the DDC channel-A input PIO: watches the 14-bit DDC/ADC sample stream, detects pulses crossing a programmable threshold and tracks each pulse's maximum.
- Presents the captured peak on a stable 14-bit bus (to the PIO in_port), with valid, length and missed-pulse information.
- Holds each result until software acknowledges it through a level output from another PIO.

Parameters:
DATA_W, 14, sample and peak width (matches PIO in_port width)
LEN_W, 10, pulse-length counter width; saturates at 2^LEN_W-1
MIN_LEN, 2, minimum above-threshold valid samples for a pulse to be accepted
MISS_W, 16, missed-pulse counter width; saturates

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
adc_data  in  DATA_W  unsigned sample
adc_valid  in  1  adc_data qualifier; samples with adc_valid=0 are ignored entirely
threshold  in  DATA_W  unsigned pulse threshold, sampled every cycle
ack  in  1  software acknowledge level; its rising edge releases HOLD
peak_out  out  DATA_W  captured pulse maximum, to PIO in_port
peak_valid  out  1  result pending acknowledge
pulse_len  out  LEN_W  above-threshold sample count of captured pulse
missed_count  out  MISS_W  pulses started while in HOLD or REARM
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): all outputs 0, run_max/run_len 0, ack_d 0, state IDLE. Reset mid-pulse discards the pulse.
- "above" = adc_valid && adc_data >= threshold. "below" = adc_valid && adc_data < threshold. Neither is true when adc_valid=0; every state holds then.
- ack_rise = ack && !ack_d. ack_d is registered every cycle. If ack is high when reset is released, there is no edge until ack falls and rises again.
- States: IDLE, PULSE, HOLD, REARM.
- IDLE:
  - above -> PULSE, run_max=adc_data, run_len=1.
  - ack_rise has no effect.
- PULSE:
  - above -> run_max=max(run_max, adc_data); run_len increments, saturating at 2^LEN_W-1.
  - below with run_len >= MIN_LEN -> registered at this edge: peak_out=run_max, pulse_len=run_len, peak_valid=1; state HOLD.
  - below with run_len < MIN_LEN -> discard, IDLE; outputs unchanged.
  - The closing below sample is never included in the max or the length.
- Latency: peak_out, pulse_len and peak_valid update on the same edge that registers the first below sample (1 clk after it is presented). peak_out changes exactly once per accepted pulse.
- HOLD:
  - peak_out and pulse_len are frozen.
  - A pulse start (above while prev_above=0) increments missed_count, saturating. prev_above updates only on valid samples and is cleared on entry to PULSE/IDLE.
  - ack_rise -> peak_valid=0. If the current sample is below (or prev_above=0) -> IDLE; else -> REARM.
  - A pulse start and ack_rise in the same cycle: the miss is counted first, then the ack is processed (-> REARM).
- REARM:
  - Waits for a below sample, then IDLE.
  - The pulse in progress is not captured; it has already been counted as missed if it started in HOLD.
- peak_out and pulse_len are never cleared by ack; they persist until the next accepted pulse.
- threshold is compared live; a change mid-pulse affects subsequent samples only.
- threshold=0: every valid sample is above, so the pulse never closes and run_len saturates. This is legal and recovered only by reset or a threshold change.
- Max tracking: ties keep the value (equal samples are indistinguishable). Arithmetic is unsigned, with no sign extension.

Test Plan:
- Basic capture: threshold=100, valid samples 50,120,300,250,90 -> one clk after the 90: peak_out=300, pulse_len=3, peak_valid=1, busy=1.
- Short pulse reject: MIN_LEN=2, threshold=100, samples 50,150,40 -> peak_valid stays 0, state IDLE, outputs unchanged.
- Gaps: samples 120,(adc_valid=0 with data 9999 for 5 clks),200,10 -> peak_out=200, pulse_len=2.
- Missed pulse and ack:
  - In HOLD, send two separate pulses -> missed_count=2.
  - ack rises while adc_data=500 is above threshold -> peak_valid=0, REARM.
  - Next below sample -> IDLE.
  - Next pulse 0x3FFF -> peak_out=16383.
- Saturation: threshold=0 for 1100 valid samples, then threshold=0x3FFF with a sample of 5 -> pulse_len=1023, peak_out=max seen.
- Reset mid-PULSE: assert reset_n=0 asynchronously -> all outputs 0 immediately. ack held high through reset -> no release until ack toggles.
